ex_issue_stage: RTL and testbench

ID/EX pipeline stage that drives the execute-stage ALU of the 16-bit pipelined CPU. It accepts decoded instructions from decode under a valid/ready handshake. It resolves operand values through EX/MEM and MEM/WB forwarding and stalls on load-use hazards. It then registers the ALU operation and operands, and squashes in-flight work when a branch flush arrives.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/ex_forward_mux.sv | 32 +++
 rtl/ex_issue_stage.sv | 156 +++++++++++++++
 tb/tb_ex_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the issue stage: opcode encodings, widths and
// opcode classification helpers.
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [OP_W-1:0] OP_ADD        = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB        = 4'd1;
  localparam logic [OP_W-1:0] OP_EVEN_UPPER = 4'd2;
  localparam logic [OP_W-1:0] OP_EVEN_LOWER = 4'd3;
  localparam logic [OP_W-1:0] OP_GTE        = 4'd4;
  localparam logic [OP_W-1:0] OP_LTZ        = 4'd5;
  localparam logic [OP_W-1:0] OP_EZ         = 4'd6;
  localparam logic [OP_W-1:0] OP_EQ         = 4'd7;
  localparam logic [OP_W-1:0] OP_NE         = 4'd8;

  // Branch comparisons occupy the contiguous range gte..ne.
  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op >= OP_GTE) && (op <= OP_NE);
  endfunction

  // Only the two-operand ops read src1; the unary ops see alu_b = 0.
  function automatic logic uses_src1(input logic [OP_W-1:0] op);
    logic w_use;
    case (op)
      OP_ADD, OP_SUB, OP_GTE, OP_EQ, OP_NE: w_use = 1'b1;
      default:                              w_use = 1'b0;
    endcase
    return w_use;
  endfunction

  // Everything above the last defined opcode is reserved.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op > OP_NE;
  endfunction

endpackage

// File: rtl/ex_forward_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats the register file,
// and r0 always reads as zero without ever forwarding.
module ex_forward_mux #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_rf_value,
  input  logic              i_exmem_wr_en,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_value,
  input  logic              i_memwb_wr_en,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_value,
  output logic [DATA_W-1:0] o_value
);

  // Priority select of the operand source.
  always_comb begin
    o_value = i_rf_value;
    if (i_src == {REG_AW{1'b0}}) begin
      o_value = {DATA_W{1'b0}};
    end else if (i_exmem_wr_en && (i_exmem_rd == i_src)) begin
      o_value = i_exmem_value;
    end else if (i_memwb_wr_en && (i_memwb_rd == i_src)) begin
      o_value = i_memwb_value;
    end else begin
      o_value = i_rf_value;
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: forwards operands, stalls on load-use, registers the
// ALU command and squashes work on a branch flush.
module ex_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [REG_AW-1:0] in_src0,
  input  logic [REG_AW-1:0] in_src1,
  input  logic [DATA_W-1:0] in_rdata0,
  input  logic [DATA_W-1:0] in_rdata1,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              exmem_wr_en,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_value,
  input  logic              exmem_is_load,
  input  logic              memwb_wr_en,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_value,
  input  logic              flush,
  input  logic              out_ready,
  output logic              alu_valid,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_en,
  output logic              out_is_branch,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  issue_count
);

  import alu_pkg::*;

  logic              r_alu_valid;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [REG_AW-1:0] r_out_rd;
  logic              r_out_wr_en;
  logic              r_out_is_branch;
  logic              r_illegal_op;
  logic [CNT_W-1:0]  r_stall_count;
  logic [CNT_W-1:0]  r_issue_count;

  logic [DATA_W-1:0] w_fwd0;
  logic [DATA_W-1:0] w_fwd1;
  logic              w_reserved;
  logic              w_use_src1;
  logic              w_hazard;
  logic              w_ready;
  logic              w_transfer;
  logic              w_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ex_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd0 (
    .i_src         (in_src0),
    .i_rf_value    (in_rdata0),
    .i_exmem_wr_en (exmem_wr_en),
    .i_exmem_rd    (exmem_rd),
    .i_exmem_value (exmem_value),
    .i_memwb_wr_en (memwb_wr_en),
    .i_memwb_rd    (memwb_rd),
    .i_memwb_value (memwb_value),
    .o_value       (w_fwd0)
  );

  ex_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .i_src         (in_src1),
    .i_rf_value    (in_rdata1),
    .i_exmem_wr_en (exmem_wr_en),
    .i_exmem_rd    (exmem_rd),
    .i_exmem_value (exmem_value),
    .i_memwb_wr_en (memwb_wr_en),
    .i_memwb_rd    (memwb_rd),
    .i_memwb_value (memwb_value),
    .o_value       (w_fwd1)
  );

  // Load-use detection and the handshake. Reserved ops read no sources, so
  // they never stall and are simply swallowed.
  always_comb begin
    w_reserved = is_reserved(in_op);
    w_use_src1 = uses_src1(in_op);
    w_hazard   = 1'b0;
    if (in_valid && exmem_is_load && exmem_wr_en && !w_reserved &&
        (exmem_rd != {REG_AW{1'b0}})) begin
      w_hazard = (exmem_rd == in_src0) || (w_use_src1 && (exmem_rd == in_src1));
    end else begin
      w_hazard = 1'b0;
    end
    w_ready    = !reset && (!r_alu_valid || out_ready) && !w_hazard && !flush;
    w_transfer = in_valid && w_ready;
    w_load     = w_transfer && !w_reserved;
  end

  // Output register, drop/pulse logic and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_valid     <= 1'b0;
      r_alu_op        <= 4'd0;
      r_alu_a         <= {DATA_W{1'b0}};
      r_alu_b         <= {DATA_W{1'b0}};
      r_out_rd        <= {REG_AW{1'b0}};
      r_out_wr_en     <= 1'b0;
      r_out_is_branch <= 1'b0;
      r_illegal_op    <= 1'b0;
      r_stall_count   <= {CNT_W{1'b0}};
      r_issue_count   <= {CNT_W{1'b0}};
    end else if (flush) begin
      r_alu_valid  <= 1'b0;
      r_out_wr_en  <= 1'b0;
      r_illegal_op <= 1'b0;
    end else begin
      r_illegal_op <= w_transfer && w_reserved;
      if (w_load) begin
        r_alu_valid     <= 1'b1;
        r_alu_op        <= in_op;
        r_alu_a         <= w_fwd0;
        r_alu_b         <= w_use_src1 ? w_fwd1 : {DATA_W{1'b0}};
        r_out_rd        <= in_rd;
        r_out_wr_en     <= in_wr_en && !is_branch(in_op);
        r_out_is_branch <= is_branch(in_op);
        r_issue_count   <= sat_inc(r_issue_count);
      end else if (r_alu_valid && out_ready) begin
        r_alu_valid <= 1'b0;
      end
      if (w_hazard) begin
        r_stall_count <= sat_inc(r_stall_count);
      end
    end
  end

  assign in_ready      = w_ready;
  assign alu_valid     = r_alu_valid;
  assign alu_op        = r_alu_op;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign out_rd        = r_out_rd;
  assign out_wr_en     = r_out_wr_en;
  assign out_is_branch = r_out_is_branch;
  assign illegal_op    = r_illegal_op;
  assign stall_count   = r_stall_count;
  assign issue_count   = r_issue_count;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: a vector table for single-issue cases
// plus hand-written load-use, hold/flush and reset-mid-stall sequences.
module tb_ex_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_src0, in_src1;
  logic [15:0] in_rdata0, in_rdata1;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        exmem_wr_en;
  logic [3:0]  exmem_rd;
  logic [15:0] exmem_value;
  logic        exmem_is_load;
  logic        memwb_wr_en;
  logic [3:0]  memwb_rd;
  logic [15:0] memwb_value;
  logic        flush;
  logic        out_ready;
  logic        alu_valid;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic        out_is_branch;
  logic        illegal_op;
  logic [15:0] stall_count, issue_count;

  int n_checks = 0;
  int n_errors = 0;

  ex_issue_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src0(in_src0), .in_src1(in_src1),
    .in_rdata0(in_rdata0), .in_rdata1(in_rdata1), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_value(exmem_value),
    .exmem_is_load(exmem_is_load), .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
    .memwb_value(memwb_value), .flush(flush), .out_ready(out_ready),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_is_branch(out_is_branch),
    .illegal_op(illegal_op), .stall_count(stall_count), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  s0, s1;
    logic [15:0] d0, d1;
    logic        ex_wr;
    logic [3:0]  ex_rd;
    logic [15:0] ex_val;
    logic        ex_ld;
    logic        mw_wr;
    logic [3:0]  mw_rd;
    logic [15:0] mw_val;
    logic        e_rdy, e_vld;
    logic [15:0] e_a, e_b;
    logic        e_wr, e_br, e_ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_op = 4'd0; in_src0 = 4'd0; in_src1 = 4'd0;
    in_rdata0 = 16'd0; in_rdata1 = 16'd0; in_rd = 4'd0; in_wr_en = 1'b0;
    exmem_wr_en = 1'b0; exmem_rd = 4'd0; exmem_value = 16'd0; exmem_is_load = 1'b0;
    memwb_wr_en = 1'b0; memwb_rd = 4'd0; memwb_value = 16'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [3:0] rd);
    in_valid = 1'b1; in_op = op; in_src0 = s0; in_src1 = s1;
    in_rdata0 = d0; in_rdata1 = d1; in_rd = rd; in_wr_en = 1'b1;
  endtask

  initial begin
    //           op    s0    s1    d0        d1        exw   exrd  exval     ld    mww   mwrd  mwval     rdy   vld   a         b         wr    br    ill
    vecs[0] = '{4'd0, 4'd1, 4'd2, 16'd5,    16'd7,    1'b1, 4'd1, 16'd100,  1'b0, 1'b0, 4'd0, 16'd0,    1'b1, 1'b1, 16'd100,  16'd7,    1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'd1, 4'd2, 4'd2, 16'd1,    16'd1,    1'b1, 4'd2, 16'd9,    1'b0, 1'b1, 4'd2, 16'd4,    1'b1, 1'b1, 16'd9,    16'd9,    1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd3, 16'd77,   16'd1,    1'b1, 4'd0, 16'd55,   1'b0, 1'b1, 4'd3, 16'd66,   1'b1, 1'b1, 16'd0,    16'd66,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'd5, 4'd4, 4'd5, 16'h8000, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b1, 1'b0, 4'd0, 16'd0,    1'b1, 1'b1, 16'h8000, 16'd0,    1'b0, 1'b1, 1'b0};
    vecs[4] = '{4'd2, 4'd6, 4'd7, 16'h1234, 16'h5678, 1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd6, 16'd999,  1'b1, 1'b1, 16'h1234, 16'd0,    1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'd8, 4'd8, 4'd9, 16'd3,    16'd4,    1'b0, 4'd0, 16'd0,    1'b0, 1'b1, 4'd9, 16'hBEEF, 1'b1, 1'b1, 16'd3,    16'hBEEF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd4, 4'd11,4'd10,16'h0F0F, 16'd2,    1'b0, 4'd10,16'd1,    1'b0, 1'b1, 4'd10,16'h0A0A, 1'b1, 1'b1, 16'h0F0F, 16'h0A0A, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'd12,4'd1, 4'd2, 16'd1,    16'd2,    1'b0, 4'd0, 16'd0,    1'b0, 1'b0, 4'd0, 16'd0,    1'b1, 1'b0, 16'd0,    16'd0,    1'b0, 1'b0, 1'b1};
    vecs[8] = '{4'd3, 4'd13,4'd0, 16'h00FF, 16'd9,    1'b1, 4'd13,16'hABCD, 1'b0, 1'b1, 4'd13,16'h1111, 1'b1, 1'b1, 16'hABCD, 16'd0,    1'b1, 1'b0, 1'b0};
    vecs[9] = '{4'd15,4'd0, 4'd0, 16'd0,    16'd0,    1'b1, 4'd1, 16'd1,    1'b1, 1'b0, 4'd0, 16'd0,    1'b1, 1'b0, 16'd0,    16'd0,    1'b0, 1'b0, 1'b1};

    clk = 1'b0;
    set_idle();
    reset = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    chk("ready_in_reset", in_ready, 1'b0);
    chk("rst_valid", alu_valid, 1'b0);
    chk("rst_op", alu_op, 4'd0);
    chk("rst_a", alu_a, 16'd0);
    chk("rst_b", alu_b, 16'd0);
    chk("rst_stall", stall_count, 16'd0);
    chk("rst_issue", issue_count, 16'd0);
    reset = 1'b0;
    set_idle();

    // Table: one instruction per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      set_instr(vecs[i].op, vecs[i].s0, vecs[i].s1, vecs[i].d0, vecs[i].d1, 4'd3);
      exmem_wr_en = vecs[i].ex_wr; exmem_rd = vecs[i].ex_rd;
      exmem_value = vecs[i].ex_val; exmem_is_load = vecs[i].ex_ld;
      memwb_wr_en = vecs[i].mw_wr; memwb_rd = vecs[i].mw_rd; memwb_value = vecs[i].mw_val;
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vecs[i].e_rdy);
      tick();
      chk($sformatf("v%0d_valid", i), alu_valid, vecs[i].e_vld);
      chk($sformatf("v%0d_illegal", i), illegal_op, vecs[i].e_ill);
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_op", i), alu_op, vecs[i].op);
        chk($sformatf("v%0d_a", i), alu_a, vecs[i].e_a);
        chk($sformatf("v%0d_b", i), alu_b, vecs[i].e_b);
        chk($sformatf("v%0d_rd", i), out_rd, 4'd3);
        chk($sformatf("v%0d_wr_en", i), out_wr_en, vecs[i].e_wr);
        chk($sformatf("v%0d_branch", i), out_is_branch, vecs[i].e_br);
      end
    end
    set_idle();
    tick();
    chk("tbl_issue_count", issue_count, 16'd8);
    chk("tbl_stall_count", stall_count, 16'd0);
    chk("tbl_illegal_clear", illegal_op, 1'b0);

    // Load-use stall on eq, then issue once the load resolves.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_instr(4'd7, 4'd1, 4'd2, 16'd7, 16'd8, 4'd6);
    exmem_is_load = 1'b1; exmem_wr_en = 1'b1; exmem_rd = 4'd2; exmem_value = 16'd0;
    #1;
    chk("lu_ready_low", in_ready, 1'b0);
    tick();
    chk("lu_stall_count", stall_count, 16'd1);
    chk("lu_no_valid", alu_valid, 1'b0);
    exmem_is_load = 1'b0; exmem_value = 16'd42;
    #1;
    chk("lu_ready_high", in_ready, 1'b1);
    tick();
    chk("lu_valid", alu_valid, 1'b1);
    chk("lu_a", alu_a, 16'd7);
    chk("lu_b", alu_b, 16'd42);
    chk("lu_wr_en", out_wr_en, 1'b0);
    chk("lu_branch", out_is_branch, 1'b1);
    chk("lu_issue", issue_count, 16'd1);
    chk("lu_stall_hold", stall_count, 16'd1);

    // Hold for three cycles with out_ready low, then flush.
    set_idle();
    set_instr(4'd0, 4'd1, 4'd2, 16'd10, 16'd20, 4'd4);
    tick();
    chk("hold_issue", issue_count, 16'd2);
    out_ready = 1'b0;
    set_instr(4'd1, 4'd1, 4'd2, 16'd99, 16'd98, 4'd9);
    exmem_wr_en = 1'b1; exmem_rd = 4'd1; exmem_value = 16'd500;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_ready", c), in_ready, 1'b0);
      tick();
      chk($sformatf("hold%0d_valid", c), alu_valid, 1'b1);
      chk($sformatf("hold%0d_op", c), alu_op, 4'd0);
      chk($sformatf("hold%0d_a", c), alu_a, 16'd10);
      chk($sformatf("hold%0d_b", c), alu_b, 16'd20);
      chk($sformatf("hold%0d_rd", c), out_rd, 4'd4);
    end
    flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 1'b0);
    tick();
    chk("flush_valid", alu_valid, 1'b0);
    chk("flush_wr_en", out_wr_en, 1'b0);
    chk("flush_issue", issue_count, 16'd2);

    // Stalls under back-pressure and flush, then reset mid-stall.
    set_idle();
    set_instr(4'd0, 4'd1, 4'd2, 16'd3, 16'd4, 4'd5);
    tick();
    chk("c_issue", issue_count, 16'd3);
    out_ready = 1'b0;
    set_instr(4'd0, 4'd2, 4'd3, 16'd0, 16'd0, 4'd7);
    exmem_is_load = 1'b1; exmem_wr_en = 1'b1; exmem_rd = 4'd2;
    tick();
    tick();
    chk("bp_stall_count", stall_count, 16'd3);
    flush = 1'b1;
    tick();
    chk("flush_stall_not_counted", stall_count, 16'd3);
    flush = 1'b0;
    tick();
    chk("stall_after_flush", stall_count, 16'd4);
    chk("c_a_held", alu_a, 16'd3);
    reset = 1'b1;
    #1;
    chk("mid_reset_ready", in_ready, 1'b0);
    tick();
    chk("mr_valid", alu_valid, 1'b0);
    chk("mr_a", alu_a, 16'd0);
    chk("mr_b", alu_b, 16'd0);
    chk("mr_rd", out_rd, 4'd0);
    chk("mr_stall", stall_count, 16'd0);
    chk("mr_issue", issue_count, 16'd0);
    reset = 1'b0;
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
